// File: rtl/dafx_gain_ramp_scheduler.sv
// Time-shared gain ramp engine between the control registers and the mixer.
// One channel is visited per clock in a round-robin sweep started by each
// audio sample tick, so one subtractor/comparator pair serves every channel.
// Each live gain moves toward its target by at most cr_ramp_step per sweep.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a sample tick (or a tick held over as pending)
// ST_SWEEP  | updating channel idx, one channel per cycle
// ST_FINISH | one cycle: refresh ramp_busy, maybe pulse ramp_done
module dafx_gain_ramp_scheduler #(
    parameter int GAIN_WIDTH_C = 24,
    parameter int Q_BITS_C     = 16,
    parameter int N_CHANNELS_C = 4,
    parameter int STEP_WIDTH_C = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 x_sample_tick,
    input  logic                                 cr_ramp_enable,
    input  logic [STEP_WIDTH_C-1:0]              cr_ramp_step,
    input  logic [N_CHANNELS_C*GAIN_WIDTH_C-1:0] cr_target_gain,
    input  logic                                 cmd_clear_overrun,
    output logic [N_CHANNELS_C*GAIN_WIDTH_C-1:0] gain_out,
    output logic                                 ramp_busy,
    output logic                                 ramp_done,
    output logic                                 sr_tick_overrun
);

    localparam int IDX_W = (N_CHANNELS_C > 1) ? $clog2(N_CHANNELS_C) : 1;
    localparam logic [GAIN_WIDTH_C-1:0] UNITY_C =
        {{(GAIN_WIDTH_C-1){1'b0}}, 1'b1} << Q_BITS_C;
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(N_CHANNELS_C - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    pending;
    logic [GAIN_WIDTH_C-1:0] gain_r [N_CHANNELS_C];

    logic [GAIN_WIDTH_C-1:0] g_cur;
    logic [GAIN_WIDTH_C-1:0] t_cur;
    logic [GAIN_WIDTH_C-1:0] step_ext;
    logic [GAIN_WIDTH_C-1:0] up_diff;
    logic [GAIN_WIDTH_C-1:0] dn_diff;
    logic [GAIN_WIDTH_C-1:0] g_next;
    logic                    all_settled;

    assign g_cur    = gain_r[idx];
    assign t_cur    = cr_target_gain[idx*GAIN_WIDTH_C +: GAIN_WIDTH_C];
    assign step_ext = GAIN_WIDTH_C'(cr_ramp_step);
    // Differences are only used on the side where they cannot wrap.
    assign up_diff  = t_cur - g_cur;
    assign dn_diff  = g_cur - t_cur;

    // Next value for the channel being visited; clamps to target instead of overshooting.
    always_comb begin
        g_next = g_cur;
        if (!cr_ramp_enable) begin
            g_next = t_cur;
        end else if (g_cur < t_cur) begin
            g_next = (up_diff <= step_ext) ? t_cur : g_cur + step_ext;
        end else if (g_cur > t_cur) begin
            g_next = (dn_diff <= step_ext) ? t_cur : g_cur - step_ext;
        end
    end

    // All-channel settled check, consumed only in ST_FINISH.
    always_comb begin
        all_settled = 1'b1;
        for (int k = 0; k < N_CHANNELS_C; k++) begin
            if (gain_r[k] != cr_target_gain[k*GAIN_WIDTH_C +: GAIN_WIDTH_C]) begin
                all_settled = 1'b0;
            end
        end
    end

    // Pack the live gains for the mixer.
    always_comb begin
        gain_out = '0;
        for (int k = 0; k < N_CHANNELS_C; k++) begin
            gain_out[k*GAIN_WIDTH_C +: GAIN_WIDTH_C] = gain_r[k];
        end
    end

    // Sequencer, per-channel gain registers, status flags and tick bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            pending         <= 1'b0;
            ramp_busy       <= 1'b0;
            ramp_done       <= 1'b0;
            sr_tick_overrun <= 1'b0;
            for (int k = 0; k < N_CHANNELS_C; k++) begin
                gain_r[k] <= UNITY_C;
            end
        end else begin
            ramp_done <= 1'b0;

            // A tick outside IDLE is held over once; a second one is dropped and flagged.
            if (x_sample_tick && (state != ST_IDLE) && pending) begin
                sr_tick_overrun <= 1'b1;
            end else if (cmd_clear_overrun) begin
                sr_tick_overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (x_sample_tick || pending) begin
                        state   <= ST_SWEEP;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (x_sample_tick) pending <= 1'b1;
                    gain_r[idx] <= g_next;
                    if (idx == LAST_IDX_C) begin
                        state <= ST_FINISH;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_FINISH: begin
                    if (x_sample_tick) pending <= 1'b1;
                    ramp_busy <= ~all_settled;
                    ramp_done <= ramp_busy && all_settled;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dafx_gain_ramp_scheduler.sv
// Directed bench for dafx_gain_ramp_scheduler with hand-computed expectations.
module tb_dafx_gain_ramp_scheduler;

    localparam int G = 24;
    localparam int N = 4;
    localparam int S = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           x_sample_tick = 1'b0;
    logic           cr_ramp_enable = 1'b1;
    logic [S-1:0]   cr_ramp_step = 16'd300;
    logic [N*G-1:0] cr_target_gain;
    logic           cmd_clear_overrun = 1'b0;
    logic [N*G-1:0] gain_out;
    logic           ramp_busy;
    logic           ramp_done;
    logic           sr_tick_overrun;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base;

    dafx_gain_ramp_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .x_sample_tick     (x_sample_tick),
        .cr_ramp_enable    (cr_ramp_enable),
        .cr_ramp_step      (cr_ramp_step),
        .cr_target_gain    (cr_target_gain),
        .cmd_clear_overrun (cmd_clear_overrun),
        .gain_out          (gain_out),
        .ramp_busy         (ramp_busy),
        .ramp_done         (ramp_done),
        .sr_tick_overrun   (sr_tick_overrun)
    );

    always #5 clk = ~clk;

    // Count ramp_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (ramp_done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int k);
        return 32'(gain_out[k*G +: G]);
    endfunction

    task automatic set_target(input int k, input logic [G-1:0] v);
        cr_target_gain[k*G +: G] = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the next negedge with the tick dropped.
    task automatic pulse_tick();
        x_sample_tick = 1'b1;
        @(negedge clk);
        x_sample_tick = 1'b0;
    endtask

    initial begin
        int exp_ch0 [4];
        exp_ch0 = '{65836, 66136, 66436, 66536};
        for (int k = 0; k < N; k++) set_target(k, 24'd65536);

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        for (int k = 0; k < N; k++) check_eq($sformatf("reset_ch%0d", k), ch(k), 65536);
        check_eq("reset_busy", ramp_busy, 0);
        check_eq("reset_done", ramp_done, 0);
        check_eq("reset_overrun", sr_tick_overrun, 0);

        // Upward ramp on ch0, step 300
        set_target(0, 24'd66536);
        done_base = done_cnt;
        for (int t = 0; t < 4; t++) begin
            pulse_tick();
            cycles(4);
            check_eq($sformatf("up_done_early_t%0d", t), ramp_done, 0);
            cycles(1);
            check_eq($sformatf("up_done_t%0d", t), ramp_done, (t == 3) ? 1 : 0);
            cycles(1);
            check_eq($sformatf("up_done_after_t%0d", t), ramp_done, 0);
            cycles(13);
            check_eq($sformatf("up_ch0_t%0d", t), ch(0), exp_ch0[t]);
            check_eq($sformatf("up_busy_t%0d", t), ramp_busy, (t < 3) ? 1 : 0);
        end
        check_eq("up_done_count", done_cnt - done_base, 1);
        for (int k = 1; k < N; k++) check_eq($sformatf("up_other_ch%0d", k), ch(k), 65536);

        // Downward ramp on ch2 with clamp
        set_target(2, 24'd65000);
        pulse_tick();
        cycles(19);
        check_eq("down_ch2_1", ch(2), 65236);
        check_eq("down_busy_1", ramp_busy, 1);
        pulse_tick();
        cycles(19);
        check_eq("down_ch2_2", ch(2), 65000);
        check_eq("down_busy_2", ramp_busy, 0);

        // Direct follow with ramping disabled
        cr_ramp_enable = 1'b0;
        set_target(3, 24'd0);
        pulse_tick();
        cycles(19);
        check_eq("bypass_ch3", ch(3), 0);
        check_eq("bypass_ch0", ch(0), 66536);
        cr_ramp_enable = 1'b1;

        // Tick spacing: second tick pends, third overruns
        set_target(1, 24'd66536);
        pulse_tick();
        @(negedge clk);
        pulse_tick();
        @(negedge clk);
        pulse_tick();
        check_eq("overrun_set", sr_tick_overrun, 1);
        cycles(20);
        check_eq("overrun_two_sweeps_ch1", ch(1), 66136);
        check_eq("overrun_held", sr_tick_overrun, 1);
        cmd_clear_overrun = 1'b1;
        @(negedge clk);
        cmd_clear_overrun = 1'b0;
        check_eq("overrun_cleared", sr_tick_overrun, 0);
        set_target(1, 24'd66136);

        // Zero step freezes gains
        cr_ramp_step = 16'd0;
        set_target(0, 24'd70000);
        cycles(2);
        done_base = done_cnt;
        for (int t = 0; t < 10; t++) begin
            pulse_tick();
            cycles(7);
        end
        check_eq("freeze_ch0", ch(0), 66536);
        check_eq("freeze_busy", ramp_busy, 1);
        check_eq("freeze_no_done", done_cnt - done_base, 0);

        // Reset mid-sweep, then restart from channel 0
        cr_ramp_step = 16'd300;
        pulse_tick();
        @(negedge clk);
        check_eq("midsweep_ch0_stepped", ch(0), 66836);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) check_eq($sformatf("midrst_ch%0d", k), ch(k), 65536);
        check_eq("midrst_busy", ramp_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        pulse_tick();
        check_eq("restart_ch0_n1", ch(0), 65536);
        @(negedge clk);
        check_eq("restart_ch0_n2", ch(0), 65836);
        check_eq("restart_ch1_n2", ch(1), 65536);
        @(negedge clk);
        check_eq("restart_ch1_n3", ch(1), 65836);
        @(negedge clk);
        check_eq("restart_ch2_n4", ch(2), 65236);
        @(negedge clk);
        check_eq("restart_ch3_n5", ch(3), 65236);
        cycles(3);
        check_eq("restart_busy", ramp_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dafx_gain_ramp_scheduler.md
Name: dafx_gain_ramp_scheduler

Overview:
- Time-shared ramp engine between the register-slave gain control registers and the mixer datapath.
- Software writes target gains; this block moves each channel's live gain toward its target by at most one step per audio sample.
- The sequencer visits one channel per clock cycle, round-robin, so a single adder/comparator serves all channels.
- This removes zipper noise on gain changes.

Parameters:
GAIN_WIDTH_C, 24, width of each unsigned fixed-point gain
Q_BITS_C, 16, fractional bits; unity gain = 1<<Q_BITS_C
N_CHANNELS_C, 4, gains handled (output gain + 3 channel gains); range 2..16
STEP_WIDTH_C, 16, width of the ramp step register

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
x_sample_tick  input  1  one-cycle strobe at audio sample rate
cr_ramp_enable  input  1  1 = ramp; 0 = gains follow targets directly
cr_ramp_step  input  STEP_WIDTH_C  maximum gain change per sample, unsigned
cr_target_gain  input  N_CHANNELS_C*GAIN_WIDTH_C  packed targets; channel k at [k*G +: G]
cmd_clear_overrun  input  1  one-cycle pulse, clears sr_tick_overrun
gain_out  output  N_CHANNELS_C*GAIN_WIDTH_C  live gains to mixer, registered, same packing
ramp_busy  output  1  registered; 1 while any gain_out channel differs from its target
ramp_done  output  1  one-cycle pulse when a sweep ends with all channels settled after at least one was not
sr_tick_overrun  output  1  sticky; a tick arrived while one was already pending

Behaviour:
- Reset (async assert, sync deassert by clock edge):
  - every gain_out channel = 1<<Q_BITS_C
  - ramp_busy = 0, ramp_done = 0, sr_tick_overrun = 0
  - FSM = IDLE, channel index = 0, pending flag = 0
- Reset mid-sweep abandons the sweep; channels already stepped return to unity.
- FSM states:
  - IDLE: if x_sample_tick or pending, go to SWEEP with idx = 0 and clear pending.
  - SWEEP: update channel idx each cycle. If idx == N_CHANNELS_C-1, go to FINISH; else idx <= idx+1.
  - FINISH: for one cycle, set ramp_busy from the all-settled check. Pulse ramp_done if busy was 1 and all channels are now settled. Go to IDLE.
- Per-channel update in SWEEP (t = target[idx], g = gain_out[idx], s = cr_ramp_step zero-extended to GAIN_WIDTH_C):
  - cr_ramp_enable == 0: g <= t.
  - g < t: g <= (t - g <= s) ? t : g + s.
  - g > t: g <= (g - t <= s) ? t : g - s.
  - g == t: no change.
  - Clamping to t guarantees no overflow or underflow. Compare using differences, never g+s, so nothing wraps at full scale.
  - s == 0 with enable = 1: gains are frozen. ramp_busy stays 1 and ramp_done never fires.
- Target sampling: each channel's target is sampled in that channel's own SWEEP cycle. A target write mid-sweep affects only channels not yet visited in the current sweep.
- Latency: with tick high in cycle c, channel k's new value appears after the edge ending cycle c+1+k. ramp_done is high in cycle c+2+N_CHANNELS_C. Sweep period = N_CHANNELS_C+2 cycles.
- Tick handling:
  - Tick outside IDLE sets pending.
  - Tick while pending is already 1 sets sr_tick_overrun; that tick is dropped.
  - cmd_clear_overrun clears the flag. If clear and a new overrun occur in the same cycle, set wins.
  - Tick and pending both present in IDLE count as one sweep.
- ramp_busy updates only in FINISH (stable between sweeps). It also updates on reset.

Test Plan:
- Reset, no ticks -> every gain_out = 65536; ramp_busy = 0; ramp_done = 0; sr_tick_overrun = 0.
- Target ch0 = 66536, step = 300, enable = 1, 4 ticks spaced 20 cycles -> ch0 = 65836, 66136, 66436, 66536. ramp_busy = 1 after sweeps 1-3. ramp_done pulses once, in cycle c+6 of tick 4. Other channels stay at 65536.
- Target ch2 = 65000, step = 300 -> ch2 = 65236, then 65000 (clamped, no undershoot). Then target ch3 = 0 with enable = 0 -> ch3 = 0 after one sweep, no ramp.
- Ticks 2 cycles apart, then a third tick before the first sweep ends -> second tick runs a sweep immediately after the first. Third tick sets sr_tick_overrun = 1. cmd_clear_overrun returns it to 0.
- Step = 0, enable = 1, target differs -> gains unchanged over 10 ticks; ramp_busy = 1; no ramp_done.
- rst_n low mid-sweep (idx = 2) -> all gains return to 65536 immediately. After release, the next tick restarts the sweep from idx = 0.
